// File: rtl/n_subtractor_if.sv
// Operand/result bundle for the registered N-bit subtractor.
// The master drives the operands; the slave returns the difference and its status flags.
interface n_subtractor_if #(
  parameter int unsigned N = 4
);
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic [N-1:0] z;
  logic         Cout;
  logic         negative_flag;
  logic         zero_flag;

  modport master (
    output A,
    output B,
    input  z,
    input  Cout,
    input  negative_flag,
    input  zero_flag
  );

  modport slave (
    input  A,
    input  B,
    output z,
    output Cout,
    output negative_flag,
    output zero_flag
  );
endinterface

// File: rtl/n_subtractor.sv
// Registered unsigned subtractor: z = (A - B) mod 2^N, built as a ripple of full adders on A + ~B + 1.
// Cout, negative_flag and zero_flag are registered in the same cycle as z.
module n_subtractor #(
  parameter int unsigned N = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  n_subtractor_if.slave   bus
);

  logic [N-1:0] b_inv;
  logic [N-1:0] diff_c;
  logic [N:0]   carry_c;
  logic         zero_c;

  assign b_inv      = ~bus.B;
  assign carry_c[0] = 1'b1;

  // One full-adder cell per bit; the +1 of two's complement enters as stage 0 carry-in
  for (genvar i = 0; i < N; i++) begin : g_fa
    logic p;
    assign p            = bus.A[i] ^ b_inv[i];
    assign diff_c[i]    = p ^ carry_c[i];
    assign carry_c[i+1] = (bus.A[i] & b_inv[i]) | (carry_c[i] & p);
  end

  assign zero_c = (diff_c == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.z             <= '0;
      bus.Cout          <= 1'b0;
      bus.negative_flag <= 1'b0;
      bus.zero_flag     <= 1'b0;
    end else begin
      bus.z             <= diff_c;
      bus.Cout          <= carry_c[N];
      bus.negative_flag <= ~carry_c[N];
      bus.zero_flag     <= zero_c;
    end
  end

endmodule

// File: tb/tb_n_subtractor.sv
// Scoreboard bench for n_subtractor (N = 4): directed vectors push expected results, and a monitor checks them one edge later.
module tb_n_subtractor;

  typedef struct packed {
    logic [3:0] z;
    logic       c;
    logic       n;
    logic       zf;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;
  exp_t q[$];

  n_subtractor_if #(.N(4)) bus ();

  n_subtractor #(.N(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, " z"},    32'(bus.z), 32'h0);
    check({tag, " Cout"}, 32'(bus.Cout), 32'h0);
    check({tag, " neg"},  32'(bus.negative_flag), 32'h0);
    check({tag, " zero"}, 32'(bus.zero_flag), 32'h0);
  endtask

  // Drive a vector before the next rising edge and record what it must produce
  task automatic run_vec(input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] z, input logic c, input logic n, input logic zf);
    @(negedge clk);
    bus.A = a;
    bus.B = b;
    q.push_back({z, c, n, zf});
  endtask

  // Monitor: every edge out of reset presents one result for the oldest expectation
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (rst_n && q.size() > 0) begin
      e = q.pop_front();
      check("z",    32'(bus.z), 32'(e.z));
      check("Cout", 32'(bus.Cout), 32'(e.c));
      check("neg",  32'(bus.negative_flag), 32'(e.n));
      check("zero", 32'(bus.zero_flag), 32'(e.zf));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    bus.A = 4'd5;
    bus.B = 4'd3;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");

    // Release with 5-3 already on the operands
    @(negedge clk);
    rst_n = 1'b1;
    q.push_back({4'b0010, 1'b1, 1'b0, 1'b0});

    run_vec(4'b0101, 4'b1100, 4'b1001, 1'b0, 1'b1, 1'b0);
    run_vec(4'b1010, 4'b1111, 4'b1011, 1'b0, 1'b1, 1'b0);
    run_vec(4'b1111, 4'b1111, 4'b0000, 1'b1, 1'b0, 1'b1);
    run_vec(4'd1, 4'd2, 4'b1111, 1'b0, 1'b1, 1'b0);
    run_vec(4'd1, 4'd7, 4'b1010, 1'b0, 1'b1, 1'b0);
    run_vec(4'd2, 4'd3, 4'b1111, 1'b0, 1'b1, 1'b0);
    run_vec(4'd2, 4'd6, 4'b1100, 1'b0, 1'b1, 1'b0);
    run_vec(4'd3, 4'd7, 4'b1100, 1'b0, 1'b1, 1'b0);
    run_vec(4'd0, 4'd15, 4'b0001, 1'b0, 1'b1, 1'b0);
    run_vec(4'd15, 4'd0, 4'b1111, 1'b1, 1'b0, 1'b0);
    run_vec(4'b0111, 4'b0011, 4'b0100, 1'b1, 1'b0, 1'b0);

    // Asynchronous reset between edges while z = 0100
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_zero("async reset");
    repeat (2) @(posedge clk);

    @(negedge clk);
    rst_n = 1'b1;
    bus.A = 4'd9;
    bus.B = 4'd4;
    q.push_back({4'b0101, 1'b1, 1'b0, 1'b0});
    run_vec(4'd6, 4'd6, 4'b0000, 1'b1, 1'b0, 1'b1);

    repeat (3) @(posedge clk);
    #2;
    check("queue drained", 32'(q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
